// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive-path constants and state encodings.
// Control FSM codes live beside the bit-level receiver codes.
package uart_rx_ctrl_pkg;

  localparam logic [2:0] rxIdle  = 3'd0;
  localparam logic [2:0] rxStart = 3'd1;
  localparam logic [2:0] rxData  = 3'd2;
  localparam logic [2:0] rxStop  = 3'd3;

  localparam logic [2:0] ctrlOff     = 3'd4;
  localparam logic [2:0] ctrlArmed   = 3'd5;
  localparam logic [2:0] ctrlActive  = 3'd6;
  localparam logic [2:0] ctrlQuiesce = 3'd7;

  typedef enum logic [2:0] {
    CTRL_OFF     = ctrlOff,
    CTRL_ARMED   = ctrlArmed,
    CTRL_ACTIVE  = ctrlActive,
    CTRL_QUIESCE = ctrlQuiesce
  } ctrl_state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [15:0] DEFAULT_DIV = 16'd26;
  localparam int unsigned IDLE_BITS   = 10;
  localparam int unsigned FIFO_DEPTH  = 8;

  function automatic int unsigned idle_limit(
    input int unsigned bits,
    input int unsigned os
  );
    return bits * os;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Byte FIFO with a registered show-ahead head.
// Writes to an empty FIFO appear on the head one edge later.
module rx_byte_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          wr_i,
  input  logic [7:0]    wdata_i,
  input  logic          rd_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, rptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          wr_ok, rd_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign rd_ok   = rd_i && !empty_o;
  assign wr_ok   = wr_i && (!full_o || rd_ok);
  assign rptr_nx = rptr_q + AW'(1);

  always_comb begin
    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Head tracks the entry that will be at rptr after this edge.
  always_comb begin
    head_d = head_q;
    if (rd_ok) begin
      if (count_q == CW'(1)) begin
        if (wr_ok) head_d = wdata_i;
      end else begin
        head_d = mem_q[rptr_nx];
      end
    end else if (wr_ok && empty_o) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= 8'h00;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_nx;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign rdata_o = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: run/stop FSM, oversample ticks,
// idle timeout, byte buffering and error reporting.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = uart_rx_ctrl_pkg::DEFAULT_DIV,
  parameter int unsigned OVERSAMPLE  = uart_rx_ctrl_pkg::OVERSAMPLE,
  parameter int unsigned IDLE_BITS   = uart_rx_ctrl_pkg::IDLE_BITS,
  parameter int unsigned FIFO_DEPTH  = uart_rx_ctrl_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       cfgWe,
  input  logic [15:0]                cfgDivisor,
  input  logic                       cfgEnable,
  output logic                       sampleTick,
  output logic                       rxEnable,
  input  logic                       rxValid,
  input  logic [7:0]                 rxByte,
  input  logic                       rxFrameErr,
  output logic [7:0]                 outData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic                       overrun,
  output logic                       frameErr,
  input  logic                       errClear,
  output logic                       idleTimeout
);

  localparam int unsigned LIMIT = idle_limit(IDLE_BITS, OVERSAMPLE);
  localparam int unsigned IW    = $clog2(LIMIT + 1);

  ctrl_state_e   state_q;
  logic [15:0]   div_q, pdiv_q, tcnt_q;
  logic          en_q, pen_q, qcnt_q;
  logic [IW-1:0] idle_q;
  logic          tick_q, rxen_q, tmo_q;
  logic          accept, wrap;
  logic          stg_vld_q, ovr_q, ferr_q;
  logic [7:0]    stg_byte_q;
  logic          f_full, f_empty, f_rd, f_wr, drop;

  assign accept = rxValid && rxen_q;
  assign wrap   = (tcnt_q == div_q);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= CTRL_OFF;
      div_q   <= DEFAULT_DIV;
      en_q    <= 1'b0;
      pdiv_q  <= DEFAULT_DIV;
      pen_q   <= 1'b0;
      qcnt_q  <= 1'b0;
      tcnt_q  <= '0;
      idle_q  <= '0;
      tick_q  <= 1'b0;
      rxen_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      tmo_q  <= 1'b0;
      unique case (state_q)
        CTRL_OFF: begin
          tcnt_q <= '0;
          idle_q <= '0;
          if (cfgWe) begin
            div_q <= cfgDivisor;
            en_q  <= cfgEnable;
          end
          if (cfgWe ? cfgEnable : en_q) begin
            state_q <= CTRL_ARMED;
            rxen_q  <= 1'b1;
          end
        end
        CTRL_ARMED, CTRL_ACTIVE: begin
          if (cfgWe) begin
            pdiv_q  <= cfgDivisor;
            pen_q   <= cfgEnable;
            state_q <= CTRL_QUIESCE;
            rxen_q  <= 1'b0;
            tcnt_q  <= '0;
            idle_q  <= '0;
            qcnt_q  <= 1'b0;
          end else begin
            tick_q <= wrap;
            tcnt_q <= wrap ? '0 : tcnt_q + 16'd1;
            if (accept) begin
              idle_q  <= '0;
              state_q <= CTRL_ACTIVE;
            end else if (state_q == CTRL_ACTIVE && wrap) begin
              // Terminal tick: pulse and fall back to waiting for data.
              if (idle_q == IW'(LIMIT - 1)) begin
                idle_q  <= '0;
                tmo_q   <= 1'b1;
                state_q <= CTRL_ARMED;
              end else begin
                idle_q <= idle_q + IW'(1);
              end
            end
          end
        end
        CTRL_QUIESCE: begin
          if (cfgWe) begin
            pdiv_q <= cfgDivisor;
            pen_q  <= cfgEnable;
          end
          if (qcnt_q) begin
            qcnt_q  <= 1'b0;
            div_q   <= cfgWe ? cfgDivisor : pdiv_q;
            en_q    <= cfgWe ? cfgEnable : pen_q;
            rxen_q  <= cfgWe ? cfgEnable : pen_q;
            state_q <= (cfgWe ? cfgEnable : pen_q) ? CTRL_ARMED : CTRL_OFF;
          end else begin
            qcnt_q <= 1'b1;
          end
        end
        default: state_q <= CTRL_OFF;
      endcase
    end
  end

  assign f_rd = outValid && outReady;
  assign f_wr = stg_vld_q && (!f_full || f_rd);
  assign drop = stg_vld_q && f_full && !f_rd;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      stg_vld_q  <= 1'b0;
      stg_byte_q <= 8'h00;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      stg_vld_q <= accept && !rxFrameErr;
      if (accept) stg_byte_q <= rxByte;
      ovr_q  <= (ovr_q && !errClear) || drop;
      ferr_q <= (ferr_q && !errClear) || (accept && rxFrameErr);
    end
  end

  rx_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstN    (rstN),
    .wr_i    (f_wr),
    .wdata_i (stg_byte_q),
    .rd_i    (f_rd),
    .rdata_o (outData),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (fifoCount)
  );

  assign outValid    = !f_empty;
  assign sampleTick  = tick_q;
  assign rxEnable    = rxen_q;
  assign idleTimeout = tmo_q;
  assign overrun     = ovr_q;
  assign frameErr    = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus a random
// run scored against a queue-based buffer model.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cfgWe;
  logic [15:0] cfgDivisor;
  logic        cfgEnable;
  logic        sampleTick;
  logic        rxEnable;
  logic        rxValid;
  logic [7:0]  rxByte;
  logic        rxFrameErr;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic [3:0]  fifoCount;
  logic        overrun;
  logic        frameErr;
  logic        errClear;
  logic        idleTimeout;

  int tests = 0;
  int fails = 0;

  uart_rx_ctrl dut (
    .clk         (clk),
    .rstN        (rstN),
    .cfgWe       (cfgWe),
    .cfgDivisor  (cfgDivisor),
    .cfgEnable   (cfgEnable),
    .sampleTick  (sampleTick),
    .rxEnable    (rxEnable),
    .rxValid     (rxValid),
    .rxByte      (rxByte),
    .rxFrameErr  (rxFrameErr),
    .outData     (outData),
    .outValid    (outValid),
    .outReady    (outReady),
    .fifoCount   (fifoCount),
    .overrun     (overrun),
    .frameErr    (frameErr),
    .errClear    (errClear),
    .idleTimeout (idleTimeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int i = 0; i < 20 && outValid; i++) step();
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    rstN = 1'b0; cfgWe = 0; cfgDivisor = 0; cfgEnable = 0;
    rxValid = 0; rxByte = 0; rxFrameErr = 0;
    outReady = 0; errClear = 0;
    step(); step();
    obs = {rxEnable, sampleTick, outValid, outData,
           fifoCount, overrun, frameErr, idleTimeout};
    tests++;
    if (obs !== 19'h0) begin
      fails++; $display("FAIL reset_outputs got %h exp 0", obs);
    end
    rstN = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        step();
        if (rxEnable !== 1'b0 || sampleTick !== 1'b0) seen++;
      end
      tests++;
      if (seen != 0) begin
        fails++; $display("FAIL reset_off_idle got %0d active cycles exp 0", seen);
      end
    end
  endtask

  task automatic test_arm_ticks();
    cfgDivisor = 16'd3; cfgEnable = 1'b1; cfgWe = 1'b1;
    step();
    cfgWe = 1'b0;
    tests++;
    if (rxEnable !== 1'b1) begin
      fails++; $display("FAIL arm_rxen got %b exp 1", rxEnable);
    end
    for (int k = 1; k <= 16; k++) begin
      logic e;
      step();
      e = (k % 4 == 0);
      tests++;
      if (sampleTick !== e) begin
        fails++; $display("FAIL arm_tick k=%0d got %b exp %b", k, sampleTick, e);
      end
    end
  endtask

  task automatic test_fifo_basic();
    rxValid = 1; rxByte = 8'hA5; step();
    tests++;
    if (outValid !== 1'b0) begin
      fails++; $display("FAIL basic_nobypass got %b exp 0", outValid);
    end
    rxByte = 8'h3C; step();
    tests++;
    if (outValid !== 1'b1 || outData !== 8'hA5) begin
      fails++; $display("FAIL basic_latency got v=%b d=%h exp v=1 d=a5", outValid, outData);
    end
    rxValid = 0; step();
    tests++;
    if (fifoCount !== 4'd2 || outData !== 8'hA5) begin
      fails++; $display("FAIL basic_two got cnt=%0d d=%h exp cnt=2 d=a5", fifoCount, outData);
    end
    outReady = 1; step();
    tests++;
    if (outData !== 8'h3C || fifoCount !== 4'd1) begin
      fails++; $display("FAIL basic_read1 got d=%h cnt=%0d exp d=3c cnt=1", outData, fifoCount);
    end
    step();
    outReady = 0;
    tests++;
    if (outValid !== 1'b0) begin
      fails++; $display("FAIL basic_read2 got v=%b exp 0", outValid);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b [9];
    for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) begin
      rxValid = 1; rxByte = b[i]; step();
    end
    rxValid = 0; step(); step();
    tests++;
    if (overrun !== 1'b1 || fifoCount !== 4'd8) begin
      fails++; $display("FAIL ovr_full got ovr=%b cnt=%0d exp ovr=1 cnt=8", overrun, fifoCount);
    end
    outReady = 1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (outData !== b[i]) begin
        fails++; $display("FAIL ovr_data i=%0d got %h exp %h", i, outData, b[i]);
      end
      step();
    end
    outReady = 0;
    tests++;
    if (outValid !== 1'b0) begin
      fails++; $display("FAIL ovr_ninth_absent got v=%b exp 0", outValid);
    end
    errClear = 1; step(); errClear = 0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL ovr_clear got %b exp 0", overrun);
    end
    for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) begin
      rxValid = 1; rxByte = b[i]; step();
    end
    rxValid = 0; outReady = 1; step(); outReady = 0;
    tests++;
    if (fifoCount !== 4'd8 || overrun !== 1'b0) begin
      fails++; $display("FAIL ovr_rw got cnt=%0d ovr=%b exp cnt=8 ovr=0", fifoCount, overrun);
    end
    step();
    outReady = 1;
    for (int i = 1; i < 9; i++) begin
      tests++;
      if (outData !== b[i]) begin
        fails++; $display("FAIL ovr_rw_data i=%0d got %h exp %h", i, outData, b[i]);
      end
      step();
    end
    outReady = 0;
  endtask

  task automatic test_frame_err();
    rxValid = 1; rxByte = 8'hFF; rxFrameErr = 1; step();
    rxValid = 0; rxFrameErr = 0;
    tests++;
    if (frameErr !== 1'b1) begin
      fails++; $display("FAIL ferr_set got %b exp 1", frameErr);
    end
    step();
    tests++;
    if (fifoCount !== 4'd0 || overrun !== 1'b0) begin
      fails++; $display("FAIL ferr_nostore got cnt=%0d ovr=%b exp 0 0", fifoCount, overrun);
    end
    rxValid = 1; rxFrameErr = 1; errClear = 1; step();
    rxValid = 0; rxFrameErr = 0;
    tests++;
    if (frameErr !== 1'b1) begin
      fails++; $display("FAIL ferr_setwins got %b exp 1", frameErr);
    end
    step(); errClear = 0;
    tests++;
    if (frameErr !== 1'b0) begin
      fails++; $display("FAIL ferr_clear got %b exp 0", frameErr);
    end
  endtask

  task automatic test_idle();
    int first = -1;
    int hits = 0;
    cfgDivisor = 16'd0; cfgEnable = 1; cfgWe = 1; step();
    cfgWe = 0; step(); step();
    tests++;
    if (rxEnable !== 1'b1) begin
      fails++; $display("FAIL idle_rearm got %b exp 1", rxEnable);
    end
    rxValid = 1; rxByte = 8'h11; step(); rxValid = 0;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (idleTimeout === 1'b1) begin
        hits++;
        if (first < 0) first = k;
      end
    end
    tests++;
    if (first != 160 || hits != 1) begin
      fails++; $display("FAIL idle_timeout got first=%0d hits=%0d exp 160 1", first, hits);
    end
    drain();
  endtask

  task automatic test_quiesce();
    rxValid = 1; rxByte = 8'h42; step(); rxValid = 0; step();
    cfgDivisor = 16'd7; cfgEnable = 1; cfgWe = 1; step();
    cfgWe = 0;
    tests++;
    if (rxEnable !== 1'b0 || sampleTick !== 1'b0) begin
      fails++; $display("FAIL q_first got en=%b tk=%b exp 0 0", rxEnable, sampleTick);
    end
    rxValid = 1; rxByte = 8'h5A; step();
    tests++;
    if (rxEnable !== 1'b0) begin
      fails++; $display("FAIL q_second got %b exp 0", rxEnable);
    end
    step(); rxValid = 0;
    tests++;
    if (rxEnable !== 1'b1) begin
      fails++; $display("FAIL q_rearm got %b exp 1", rxEnable);
    end
    for (int k = 1; k <= 24; k++) begin
      logic e;
      step();
      e = (k % 8 == 0);
      tests++;
      if (sampleTick !== e) begin
        fails++; $display("FAIL q_tick k=%0d got %b exp %b", k, sampleTick, e);
      end
    end
    tests++;
    if (fifoCount !== 4'd1 || outData !== 8'h42) begin
      fails++; $display("FAIL q_ignored got cnt=%0d d=%h exp 1 42", fifoCount, outData);
    end
    drain();
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    bit pv = 0;
    logic [7:0] pb = 0;
    bit m_ovr = 0;
    bit m_ferr = 0;
    errClear = 1; step(); errClear = 0;
    for (int n = 0; n < 400; n++) begin
      bit full, rd, drop;
      rxValid    = ($urandom_range(0, 1) == 1);
      rxByte     = 8'($urandom);
      rxFrameErr = rxValid && ($urandom_range(0, 9) == 0);
      outReady   = ($urandom_range(0, 9) < 4);
      errClear   = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      full = (q.size() == 8);
      rd   = (q.size() != 0) && outReady;
      drop = 0;
      if (rd) void'(q.pop_front());
      if (pv) begin
        if (!full || rd) q.push_back(pb);
        else drop = 1;
      end
      m_ovr  = (m_ovr && !errClear) || drop;
      m_ferr = (m_ferr && !errClear) || (rxValid && rxFrameErr);
      pv = rxValid && !rxFrameErr;
      pb = rxByte;
      #1;
      tests++;
      if (fifoCount !== 4'(q.size()) || outValid !== (q.size() != 0)) begin
        fails++; $display("FAIL rnd_count n=%0d got %0d/%b exp %0d", n, fifoCount, outValid, q.size());
      end
      if (q.size() != 0) begin
        tests++;
        if (outData !== q[0]) begin
          fails++; $display("FAIL rnd_data n=%0d got %h exp %h", n, outData, q[0]);
        end
      end
      tests++;
      if (overrun !== m_ovr || frameErr !== m_ferr) begin
        fails++; $display("FAIL rnd_err n=%0d got %b%b exp %b%b", n, overrun, frameErr, m_ovr, m_ferr);
      end
    end
    rxValid = 0; rxFrameErr = 0; outReady = 0; errClear = 0;
  endtask

  task automatic test_reset_mid();
    logic [18:0] obs;
    for (int i = 0; i < 3; i++) begin
      rxValid = 1; rxByte = 8'(8'h70 + i);
      cfgWe = (i == 2); cfgDivisor = 16'd2; cfgEnable = 1;
      step();
    end
    rxValid = 0; cfgWe = 0;
    rstN = 0; step();
    obs = {rxEnable, sampleTick, outValid, outData,
           fifoCount, overrun, frameErr, idleTimeout};
    tests++;
    if (obs !== 19'h0) begin
      fails++; $display("FAIL rmid_outputs got %h exp 0", obs);
    end
    rstN = 1;
    for (int k = 0; k < 6; k++) step();
    tests++;
    if (outValid !== 1'b0 || fifoCount !== 4'd0 || rxEnable !== 1'b0) begin
      fails++; $display("FAIL rmid_after got v=%b cnt=%0d en=%b exp 0 0 0", outValid, fifoCount, rxEnable);
    end
  endtask

  initial begin
    test_reset();
    test_arm_ticks();
    test_fifo_basic();
    test_overrun();
    test_frame_err();
    test_idle();
    test_quiesce();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-path controller for the UART receiver. It owns the receiver's run/stop sequencing and the oversample tick generator, and takes the configuration (baud divisor, enable). It buffers completed bytes in a small FIFO with a valid/ready read port. It also reports overrun, framing errors and line-idle timeout. It sits between the UART receiver and the byte consumer (CPU/pipeline side).

## Interface
- DEFAULT_DIV, 16'd26: divisor loaded at reset; oversample tick period = divisor+1 clocks
- OVERSAMPLE, 16: ticks per bit time
- IDLE_BITS, 10: bit times without a byte before idle timeout
- FIFO_DEPTH, 8: byte buffer entries (power of 2)
- clk  in  1  system clock, all logic on rising edge
- rstN  in  1  synchronous, active-low reset
- cfgWe  in  1  config write strobe
- cfgDivisor  in  16  new divisor, taken when cfgWe
- cfgEnable  in  1  new enable, taken when cfgWe
- sampleTick  out  1  one-cycle oversample pulse to receiver
- rxEnable  out  1  receiver run enable
- rxValid  in  1  receiver pulse: byte complete
- rxByte  in  8  received byte, qualified by rxValid
- rxFrameErr  in  1  stop bit was low, qualified by rxValid
- outData  out  8  FIFO head byte
- outValid  out  1  FIFO non-empty
- outReady  in  1  consumer accepts head
- fifoCount  out  4  occupancy 0..FIFO_DEPTH
- overrun  out  1  sticky: byte dropped, FIFO full
- frameErr  out  1  sticky: framed byte dropped
- errClear  in  1  clears overrun and frameErr
- idleTimeout  out  1  one-cycle pulse on idle expiry

## Operation
- States: OFF, ARMED, ACTIVE, QUIESCE.
- OFF:
  - rxEnable=0, sampleTick=0, tick counter held at 0.
  - cfgWe updates divisor/enable registers.
  - Goes to ARMED when the enable register is 1.
- ARMED:
  - rxEnable=1, tick generator runs.
  - Goes to ACTIVE on the first accepted rxValid.
- ACTIVE:
  - As ARMED, plus the idle counter runs.
  - The idle counter counts sampleTicks and clears on every rxValid.
  - When it reaches IDLE_BITS*OVERSAMPLE: pulse idleTimeout, clear the counter, return to ARMED.
- cfgWe in ARMED/ACTIVE: go to QUIESCE; the new values are latched to pending registers.
- QUIESCE:
  - rxEnable=0, tick stopped, counters cleared.
  - Stays exactly 2 cycles, then commits the pending divisor/enable.
  - Goes to ARMED if enable=1, else OFF.
  - cfgWe during QUIESCE overwrites the pending values and does not extend the stay.
- Tick generator:
  - 16-bit counter 0..divisor; sampleTick=1 in the cycle the counter equals divisor, then the counter wraps to 0.
  - divisor=0 gives a tick every cycle.
- rxValid is accepted only while rxEnable=1; otherwise it is ignored.
- Accepted byte with rxFrameErr=1: not stored, frameErr set.
- Accepted good byte, FIFO not full: written.
- Accepted good byte, FIFO full and no read this cycle: dropped, overrun set.
- FIFO full with read and write in the same cycle: both happen, count unchanged.
- FIFO empty: a write is not bypassed to the output.
- A read occurs when outValid && outReady.
- errClear and a new error in the same cycle: the set wins.
- Pointers wrap modulo FIFO_DEPTH; fifoCount holds FIFO_DEPTH when full.

## Timing
- Reset (rstN=0 at an edge) gives:
  - state OFF, divisor=DEFAULT_DIV, enable=0
  - FIFO emptied
  - all outputs 0; outData=8'h00
- Reset mid-frame or mid-QUIESCE drops everything; no byte survives.
- Write latency: byte on rxValid at edge N gives outValid=1 and outData valid after edge N+1.
- outData is the registered FIFO head (show-ahead). It is stable while outValid && !outReady.
- First sampleTick after entering ARMED comes divisor+1 cycles later.
- rxEnable falls in the first QUIESCE cycle and is low for exactly 2 cycles when re-arming.
- idleTimeout is asserted for one cycle, coincident with the terminal tick.

## Structure
- Shared parameters file gets: state encodings ctrlOff/ctrlArmed/ctrlActive/ctrlQuiesce (3-bit, alongside the existing receiver state constants), OVERSAMPLE, DEFAULT_DIV.
- One sub-module, rx_byte_fifo: synchronous FIFO, 8-bit, FIFO_DEPTH entries, write/read/full/empty/count. It has no policy; overrun and frame-error policy stays in uart_rx_ctrl.
- Tick generator, idle counter and FSM stay inline.

## Test plan
- Reset, then cfgWe divisor=3, enable=1 -> rxEnable=1 next cycle; sampleTick every 4th cycle, first tick 4 cycles after ARMED.
- Push 8'hA5, 8'h3C with outReady=0 -> fifoCount=2, outData=8'hA5; outReady for 2 cycles -> 8'h3C then outValid=0.
- Fill 8 bytes, push a 9th with no read -> overrun=1, fifoCount=8, 9th byte absent. Repeat with simultaneous read -> no overrun, count stays 8.
- rxValid with rxFrameErr=1 and byte 8'hFF -> frameErr=1, fifoCount unchanged. errClear in the same cycle as another frame error -> frameErr stays 1.
- One byte, then silence with divisor=0, IDLE_BITS=10 -> idleTimeout pulses exactly 160 cycles later; state returns to ARMED.
- cfgWe divisor=7 while ACTIVE -> rxEnable low for 2 cycles, rxValid in that window ignored, ticks then every 8 cycles. Assert rstN low mid-stream -> all outputs 0 after the edge.
